// File: rtl/tx_framer.sv
// Transmit framer: scrambles a plaintext AXI-Stream with a Galois PRBS
// keystream and marks fixed-length frames with sof/eof.
module tx_framer #(
    parameter int C_CLOCK_FREQ = 100
) (
    input  logic        s_axi_aclk,
    input  logic        s_axi_aresetn,
    input  logic        i_tx_enable,
    input  logic [31:0] i_prbs_seed,
    input  logic [15:0] i_frame_len,
    input  logic [31:0] s_axis_tdata,
    input  logic        s_axis_tvalid,
    output logic        s_axis_tready,
    output logic [31:0] m_axis_tdata,
    output logic        m_axis_tvalid,
    input  logic        m_axis_tready,
    output logic        m_axis_sof,
    output logic        m_axis_eof,
    output logic        o_busy,
    output logic [31:0] o_frame_cnt
);

    typedef enum logic [1:0] {IDLE, LOAD, RUN, DRAIN} state_t;

    state_t      state;
    logic        en_d;
    logic [31:0] lfsr;
    logic [15:0] word_idx;
    logic [15:0] len;

    logic        can_take;
    logic        take_ok;
    logic        accept;
    logic        last;
    logic [15:0] len_in;
    logic [31:0] lfsr_next;

    if (C_CLOCK_FREQ < 1) begin : g_no_clk
    end

    assign len_in    = (i_frame_len == 16'd0) ? 16'd1 : i_frame_len;
    assign lfsr_next = {1'b0, lfsr[31:1]} ^ (lfsr[0] ? 32'h80200003 : 32'h0);
    assign last      = (word_idx == len - 16'd1);
    assign can_take  = !m_axis_tvalid || m_axis_tready;

    // Once disabled, only the remainder of an open frame is accepted.
    assign take_ok = ((state == RUN) && (en_d || word_idx != 16'd0)) ||
                     ((state == DRAIN) && (word_idx != 16'd0));

    assign s_axis_tready = can_take && take_ok;
    assign accept        = s_axis_tready && s_axis_tvalid;
    assign o_busy        = (state != IDLE);

    always_ff @(posedge s_axi_aclk or negedge s_axi_aresetn) begin
        if (!s_axi_aresetn) begin
            state         <= IDLE;
            en_d          <= 1'b0;
            lfsr          <= 32'h00000001;
            word_idx      <= 16'd0;
            len           <= 16'd1;
            m_axis_tdata  <= 32'h0;
            m_axis_tvalid <= 1'b0;
            m_axis_sof    <= 1'b0;
            m_axis_eof    <= 1'b0;
            o_frame_cnt   <= 32'h0;
        end else begin
            en_d <= i_tx_enable;

            if (accept) begin
                lfsr          <= lfsr_next;
                m_axis_tdata  <= s_axis_tdata ^ lfsr;
                m_axis_tvalid <= 1'b1;
                m_axis_sof    <= (word_idx == 16'd0);
                m_axis_eof    <= last;
                if (last) begin
                    word_idx <= 16'd0;
                    len      <= len_in;
                end else begin
                    word_idx <= word_idx + 16'd1;
                end
            end else if (m_axis_tready) begin
                m_axis_tvalid <= 1'b0;
            end

            if (m_axis_tvalid && m_axis_tready && m_axis_eof) begin
                o_frame_cnt <= o_frame_cnt + 32'd1;
            end

            unique case (state)
                IDLE: begin
                    if (en_d) state <= LOAD;
                end
                LOAD: begin
                    lfsr     <= (i_prbs_seed == 32'h0) ? 32'h1 : i_prbs_seed;
                    word_idx <= 16'd0;
                    len      <= len_in;
                    state    <= RUN;
                end
                RUN: begin
                    if (!en_d) begin
                        if (word_idx == 16'd0 && !m_axis_tvalid) begin
                            state <= IDLE;
                        end else begin
                            state <= DRAIN;
                        end
                    end
                end
                DRAIN: begin
                    if (word_idx == 16'd0 && !m_axis_tvalid) state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_tx_framer.sv
// Directed bench for tx_framer: vector tables for framing and
// hand-written sequences for backpressure, disable, re-enable and reset.
module tb_tx_framer;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        tx_enable = 1'b0;
    logic [31:0] prbs_seed = 32'h0;
    logic [15:0] frame_len = 16'd0;
    logic [31:0] s_tdata = 32'h0;
    logic        s_tvalid = 1'b0;
    logic        s_tready;
    logic [31:0] m_tdata;
    logic        m_tvalid;
    logic        m_tready = 1'b1;
    logic        m_sof;
    logic        m_eof;
    logic        busy;
    logic [31:0] frame_cnt;

    tx_framer #(.C_CLOCK_FREQ(100)) dut (
        .s_axi_aclk    (clk),
        .s_axi_aresetn (rst_n),
        .i_tx_enable   (tx_enable),
        .i_prbs_seed   (prbs_seed),
        .i_frame_len   (frame_len),
        .s_axis_tdata  (s_tdata),
        .s_axis_tvalid (s_tvalid),
        .s_axis_tready (s_tready),
        .m_axis_tdata  (m_tdata),
        .m_axis_tvalid (m_tvalid),
        .m_axis_tready (m_tready),
        .m_axis_sof    (m_sof),
        .m_axis_eof    (m_eof),
        .o_busy        (busy),
        .o_frame_cnt   (frame_cnt)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] pt;
        logic [31:0] data;
        logic        sof;
        logic        eof;
    } vec_t;

    vec_t        exp_q[$];
    vec_t        t1[3];
    vec_t        t2[3];
    vec_t        t5[2];
    int          n_pass = 0;
    int          n_total = 0;
    logic [31:0] ml;
    int          mi;
    int          mlen;

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%08h want 0x%08h", name, act, exp);
    endtask

    task automatic model_init(input logic [31:0] seed, input int len);
        ml   = (seed == 32'h0) ? 32'h1 : seed;
        mi   = 0;
        mlen = (len == 0) ? 1 : len;
    endtask

    task automatic push_model(input int n, input logic [31:0] pt);
        vec_t e;
        for (int i = 0; i < n; i++) begin
            e.pt   = pt;
            e.data = pt ^ ml;
            e.sof  = (mi == 0);
            e.eof  = (mi == mlen - 1);
            exp_q.push_back(e);
            ml = ml[0] ? ((ml >> 1) ^ 32'h80200003) : (ml >> 1);
            mi = e.eof ? 0 : mi + 1;
        end
    endtask

    task automatic run_words(input int n, input bit rnd);
        int          acc = 0;
        int          got = 0;
        int          cyc = 0;
        bit          pv = 0;
        logic [33:0] prev = '0;
        vec_t        e;
        while (got < n && cyc < 2000) begin
            @(negedge clk);
            m_tready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
            s_tvalid = (acc < n) && (exp_q.size() > acc - got);
            if (s_tvalid) s_tdata = exp_q[acc - got].pt;
            #1;
            if (pv) begin
                chk("hold_valid", {31'h0, m_tvalid}, 32'h1);
                chk("hold_data", m_tdata, prev[33:2]);
                chk("hold_flags", {30'h0, m_sof, m_eof}, {30'h0, prev[1:0]});
            end
            if (s_tvalid && s_tready) acc++;
            if (m_tvalid && m_tready) begin
                if (exp_q.size() > 0) begin
                    e = exp_q.pop_front();
                    chk("data", m_tdata, e.data);
                    chk("sof", {31'h0, m_sof}, {31'h0, e.sof});
                    chk("eof", {31'h0, m_eof}, {31'h0, e.eof});
                end else begin
                    chk("extra_word", 32'h1, 32'h0);
                end
                got++;
            end
            pv   = m_tvalid && !m_tready;
            prev = {m_tdata, m_sof, m_eof};
            cyc++;
        end
        chk("word_count", got, n);
        @(negedge clk);
        s_tvalid = 1'b0;
        m_tready = 1'b1;
        #1;
    endtask

    task automatic go_idle();
        tx_enable = 1'b0;
        repeat (5) @(negedge clk);
        #1;
        chk("idle_busy", {31'h0, busy}, 32'h0);
        chk("idle_tready", {31'h0, s_tready}, 32'h0);
    endtask

    initial begin
        t1[0] = '{32'h0, 32'h00000001, 1'b1, 1'b0};
        t1[1] = '{32'h0, 32'h80200003, 1'b0, 1'b0};
        t1[2] = '{32'h0, 32'hC0300002, 1'b0, 1'b1};
        t2[0] = '{32'hFFFFFFFF, 32'hFFFFFFFE, 1'b1, 1'b1};
        t2[1] = '{32'h12345678, 32'h9214567B, 1'b1, 1'b1};
        t2[2] = '{32'h00000000, 32'hC0300002, 1'b1, 1'b1};
        t5[0] = '{32'hDEADBEEF, 32'hCC99E897, 1'b1, 1'b0};
        t5[1] = '{32'hDEADBEEF, 32'hD7B795D3, 1'b0, 1'b0};

        repeat (2) @(negedge clk);
        #1;
        chk("rst_tready", {31'h0, s_tready}, 32'h0);
        chk("rst_tvalid", {31'h0, m_tvalid}, 32'h0);
        chk("rst_tdata", m_tdata, 32'h0);
        chk("rst_flags", {30'h0, m_sof, m_eof}, 32'h0);
        chk("rst_busy", {31'h0, busy}, 32'h0);
        chk("rst_cnt", frame_cnt, 32'h0);
        @(negedge clk);
        rst_n = 1'b1;

        // Seed 1, three-word frame.
        prbs_seed = 32'h1;
        frame_len = 16'd3;
        tx_enable = 1'b1;
        for (int i = 0; i < 3; i++) exp_q.push_back(t1[i]);
        run_words(3, 0);
        chk("t1_cnt", frame_cnt, 32'd1);
        chk("t1_busy", {31'h0, busy}, 32'h1);
        go_idle();

        // Zero seed and zero length: single-word frames.
        prbs_seed = 32'h0;
        frame_len = 16'd0;
        tx_enable = 1'b1;
        for (int i = 0; i < 3; i++) exp_q.push_back(t2[i]);
        run_words(3, 0);
        chk("t2_cnt", frame_cnt, 32'd4);
        go_idle();

        // Random backpressure over three frames of four.
        prbs_seed = 32'h0BADBEEF;
        frame_len = 16'd4;
        model_init(32'h0BADBEEF, 4);
        push_model(12, 32'hA5A5A5A5);
        tx_enable = 1'b1;
        run_words(12, 1);
        chk("bp_cnt", frame_cnt, 32'd7);
        go_idle();

        // Disable after word 1 of a five-word frame.
        prbs_seed = 32'h1;
        frame_len = 16'd5;
        model_init(32'h1, 5);
        push_model(5, 32'h3C3C0F0F);
        tx_enable = 1'b1;
        run_words(2, 0);
        tx_enable = 1'b0;
        run_words(3, 0);
        chk("dis_cnt", frame_cnt, 32'd8);
        go_idle();

        // Re-enable with a fresh seed, then reset mid-frame.
        prbs_seed = 32'h12345678;
        frame_len = 16'd4;
        tx_enable = 1'b1;
        for (int i = 0; i < 2; i++) exp_q.push_back(t5[i]);
        run_words(2, 0);
        @(negedge clk);
        m_tready = 1'b0;
        s_tdata  = 32'h0;
        s_tvalid = 1'b1;
        @(negedge clk);
        s_tvalid = 1'b0;
        #1;
        chk("w2_valid", {31'h0, m_tvalid}, 32'h1);
        chk("w2_data", m_tdata, 32'h048D159E);
        rst_n     = 1'b0;
        tx_enable = 1'b0;
        #1;
        chk("mrst_tvalid", {31'h0, m_tvalid}, 32'h0);
        chk("mrst_tdata", m_tdata, 32'h0);
        chk("mrst_flags", {30'h0, m_sof, m_eof}, 32'h0);
        chk("mrst_busy", {31'h0, busy}, 32'h0);
        chk("mrst_tready", {31'h0, s_tready}, 32'h0);
        chk("mrst_cnt", frame_cnt, 32'h0);
        repeat (2) @(negedge clk);
        rst_n    = 1'b1;
        m_tready = 1'b1;
        @(negedge clk);
        prbs_seed = 32'h1;
        frame_len = 16'd3;
        tx_enable = 1'b1;
        @(negedge clk);
        #1;
        chk("en_rdy_k", {31'h0, s_tready}, 32'h0);
        @(negedge clk);
        #1;
        chk("en_rdy_k1", {31'h0, s_tready}, 32'h0);
        @(negedge clk);
        #1;
        chk("en_rdy_k2", {31'h0, s_tready}, 32'h1);
        for (int i = 0; i < 3; i++) exp_q.push_back(t1[i]);
        run_words(3, 0);
        chk("post_rst_cnt", frame_cnt, 32'd1);
        go_idle();

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
